// File: rtl/cpu_pkg.sv
// Shared CPU definitions: write-back select encodings, LSU FSM states and bus width.
package cpu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    WSEL_ALU  = 2'b00,
    WSEL_DRAM = 2'b01,
    WSEL_PC4  = 2'b10,
    WSEL_IMM  = 2'b11
  } rf_wsel_e;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } lsu_state_e;

endpackage

// File: rtl/lsu_timeout_cnt.sv
// Saturating cycle counter for the LSU bus wait; tc_o flags the last allowed wait cycle.
module lsu_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_d, cnt_q;

  // Stops at LAST instead of wrapping so tc_o stays asserted until cleared.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ack data-bus transactions with stall, timeout abort
// and misalignment trapping, registering results into the MEM/WB boundary.
module mem_stage_lsu
  import cpu_pkg::*;
#(
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] aluc_i,
  input  logic [XLEN-1:0] rD2_i,
  input  logic [1:0]      rf_wsel_i,
  input  logic            ram_we_i,
  output logic            stall_o,
  output logic            bus_req_o,
  output logic            bus_we_o,
  output logic [XLEN-1:0] bus_addr_o,
  output logic [XLEN-1:0] bus_wdata_o,
  input  logic            bus_ack_i,
  input  logic [XLEN-1:0] bus_rdata_i,
  output logic            wb_valid_o,
  output logic [XLEN-1:0] wb_aluc_o,
  output logic [XLEN-1:0] wb_rdata_o,
  output logic [1:0]      wb_rf_wsel_o,
  output logic            err_o
);

  lsu_state_e      state_d, state_q;
  logic            bus_req_d, bus_req_q;
  logic            bus_we_d, bus_we_q;
  logic [XLEN-1:0] bus_addr_d, bus_addr_q;
  logic [XLEN-1:0] bus_wdata_d, bus_wdata_q;
  logic            wb_valid_d, wb_valid_q;
  logic [XLEN-1:0] wb_aluc_d, wb_aluc_q;
  logic [XLEN-1:0] wb_rdata_d, wb_rdata_q;
  logic [1:0]      wb_rf_wsel_d, wb_rf_wsel_q;
  logic            err_d, err_q;

  logic mem_op, misaligned, stall, cnt_clear, cnt_en, cnt_tc;

  assign mem_op     = ex_valid_i & (ram_we_i | (rf_wsel_i == WSEL_DRAM));
  assign misaligned = (aluc_i[1:0] != 2'b00);

  lsu_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (cnt_clear),
    .enable_i (cnt_en),
    .tc_o     (cnt_tc)
  );

  always_comb begin
    state_d      = state_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    wb_valid_d   = 1'b0;
    wb_aluc_d    = wb_aluc_q;
    wb_rdata_d   = wb_rdata_q;
    wb_rf_wsel_d = wb_rf_wsel_q;
    err_d        = 1'b0;
    stall        = 1'b0;
    cnt_clear    = 1'b0;
    cnt_en       = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_op && misaligned) begin
          // Trap without touching the bus; the store is simply dropped.
          wb_valid_d   = 1'b1;
          wb_aluc_d    = aluc_i;
          wb_rf_wsel_d = rf_wsel_i;
          wb_rdata_d   = ERR_RDATA;
          err_d        = 1'b1;
        end else if (mem_op) begin
          stall       = 1'b1;
          bus_req_d   = 1'b1;
          bus_we_d    = ram_we_i;
          bus_addr_d  = {aluc_i[XLEN-1:2], 2'b00};
          bus_wdata_d = rD2_i;
          cnt_clear   = 1'b1;
          state_d     = REQ;
        end else begin
          wb_valid_d   = ex_valid_i;
          wb_aluc_d    = aluc_i;
          wb_rf_wsel_d = rf_wsel_i;
          wb_rdata_d   = '0;
        end
      end

      REQ: begin
        cnt_en = 1'b1;
        // Ack wins over a timeout that lands in the same cycle.
        if (bus_ack_i) begin
          wb_valid_d   = 1'b1;
          wb_aluc_d    = aluc_i;
          wb_rf_wsel_d = rf_wsel_i;
          wb_rdata_d   = bus_we_q ? '0 : bus_rdata_i;
          bus_req_d    = 1'b0;
          bus_we_d     = 1'b0;
          state_d      = IDLE;
        end else if (cnt_tc) begin
          wb_valid_d   = 1'b1;
          wb_aluc_d    = aluc_i;
          wb_rf_wsel_d = rf_wsel_i;
          wb_rdata_d   = ERR_RDATA;
          err_d        = 1'b1;
          bus_req_d    = 1'b0;
          bus_we_d     = 1'b0;
          state_d      = IDLE;
        end else begin
          stall = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      wb_valid_q   <= 1'b0;
      wb_aluc_q    <= '0;
      wb_rdata_q   <= '0;
      wb_rf_wsel_q <= 2'b00;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      wb_valid_q   <= wb_valid_d;
      wb_aluc_q    <= wb_aluc_d;
      wb_rdata_q   <= wb_rdata_d;
      wb_rf_wsel_q <= wb_rf_wsel_d;
      err_q        <= err_d;
    end
  end

  // Masked by reset so a held memory op cannot raise stall while the unit is being reset.
  assign stall_o      = stall & ~rst_i;
  assign bus_req_o    = bus_req_q;
  assign bus_we_o     = bus_we_q;
  assign bus_addr_o   = bus_addr_q;
  assign bus_wdata_o  = bus_wdata_q;
  assign wb_valid_o   = wb_valid_q;
  assign wb_aluc_o    = wb_aluc_q;
  assign wb_rdata_o   = wb_rdata_q;
  assign wb_rf_wsel_o = wb_rf_wsel_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu: ALU pass-through, load/store
// handshakes, misalignment, timeout abort and reset during a transaction.
module tb_mem_stage_lsu;
  import cpu_pkg::*;

  localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

  logic        clk_i, rst_i;
  logic        ex_valid_i;
  logic [31:0] aluc_i, rD2_i;
  logic [1:0]  rf_wsel_i;
  logic        ram_we_i;
  logic        stall_o, bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic        wb_valid_o;
  logic [31:0] wb_aluc_o, wb_rdata_o;
  logic [1:0]  wb_rf_wsel_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;
  int reqCycles, stallCycles, n;

  mem_stage_lsu #(
    .TIMEOUT   (16),
    .ERR_RDATA (ERR_VAL)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ex_valid_i   (ex_valid_i),
    .aluc_i       (aluc_i),
    .rD2_i        (rD2_i),
    .rf_wsel_i    (rf_wsel_i),
    .ram_we_i     (ram_we_i),
    .stall_o      (stall_o),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_ack_i    (bus_ack_i),
    .bus_rdata_i  (bus_rdata_i),
    .wb_valid_o   (wb_valid_o),
    .wb_aluc_o    (wb_aluc_o),
    .wb_rdata_o   (wb_rdata_o),
    .wb_rf_wsel_o (wb_rf_wsel_o),
    .err_o        (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] aluc, input logic [31:0] rd2,
                               input logic [1:0] wsel, input logic we);
    ex_valid_i = valid;
    aluc_i     = aluc;
    rD2_i      = rd2;
    rf_wsel_i  = wsel;
    ram_we_i   = we;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i       = 1'b1;
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'h0;
    applyStimulus(1'b0, 32'h0, 32'h0, WSEL_ALU, 1'b0);
    repeat (2) tick();
    checkOutput("rst_wb_valid", 32'(wb_valid_o), 32'h0);
    checkOutput("rst_bus_req", 32'(bus_req_o), 32'h0);
    checkOutput("rst_err", 32'(err_o), 32'h0);
    checkOutput("rst_stall", 32'(stall_o), 32'h0);
    checkOutput("rst_wb_aluc", wb_aluc_o, 32'h0);
    rst_i = 1'b0;
    tick();

    // ALU op passes through in one cycle without stalling
    applyStimulus(1'b1, 32'h1234, 32'h0, WSEL_ALU, 1'b0);
    #1;
    checkOutput("alu_stall", 32'(stall_o), 32'h0);
    tick();
    checkOutput("alu_wb_valid", 32'(wb_valid_o), 32'h1);
    checkOutput("alu_wb_aluc", wb_aluc_o, 32'h1234);
    checkOutput("alu_wb_wsel", 32'(wb_rf_wsel_o), 32'h0);
    checkOutput("alu_stall2", 32'(stall_o), 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, WSEL_ALU, 1'b0);
    tick();
    checkOutput("idle_wb_valid", 32'(wb_valid_o), 32'h0);

    // Load, ack in the first REQ cycle
    applyStimulus(1'b1, 32'h100, 32'h0, WSEL_DRAM, 1'b0);
    bus_rdata_i = 32'hCAFE_BABE;
    #1;
    checkOutput("ld_stall_idle", 32'(stall_o), 32'h1);
    tick();
    checkOutput("ld_bus_req", 32'(bus_req_o), 32'h1);
    checkOutput("ld_bus_addr", bus_addr_o, 32'h100);
    checkOutput("ld_bus_we", 32'(bus_we_o), 32'h0);
    checkOutput("ld_bubble", 32'(wb_valid_o), 32'h0);
    bus_ack_i = 1'b1;
    #1;
    checkOutput("ld_stall_ack", 32'(stall_o), 32'h0);
    tick();
    bus_ack_i = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, WSEL_ALU, 1'b0);
    checkOutput("ld_wb_valid", 32'(wb_valid_o), 32'h1);
    checkOutput("ld_wb_rdata", wb_rdata_o, 32'hCAFE_BABE);
    checkOutput("ld_wb_wsel", 32'(wb_rf_wsel_o), 32'h1);
    checkOutput("ld_bus_req_done", 32'(bus_req_o), 32'h0);
    tick();

    // Store, ack in the third REQ cycle
    applyStimulus(1'b1, 32'h200, 32'hA5A5_A5A5, WSEL_ALU, 1'b1);
    reqCycles   = 0;
    stallCycles = 0;
    #1;
    if (stall_o) stallCycles++;
    tick();
    checkOutput("st_bus_we", 32'(bus_we_o), 32'h1);
    checkOutput("st_bus_wdata", bus_wdata_o, 32'hA5A5_A5A5);
    checkOutput("st_bus_addr", bus_addr_o, 32'h200);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus_ack_i = 1'b1;
      #1;
      if (bus_req_o) reqCycles++;
      if (stall_o) stallCycles++;
      tick();
    end
    bus_ack_i = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, WSEL_ALU, 1'b0);
    checkOutput("st_req_cycles", 32'(reqCycles), 32'd3);
    checkOutput("st_stall_cycles", 32'(stallCycles), 32'd3);
    checkOutput("st_wb_valid", 32'(wb_valid_o), 32'h1);
    checkOutput("st_wb_rdata", wb_rdata_o, 32'h0);
    checkOutput("st_bus_req_done", 32'(bus_req_o), 32'h0);
    tick();

    // Misaligned load: no bus cycle, one-cycle error
    applyStimulus(1'b1, 32'h102, 32'h0, WSEL_DRAM, 1'b0);
    #1;
    checkOutput("mis_ld_stall", 32'(stall_o), 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, WSEL_ALU, 1'b0);
    checkOutput("mis_ld_bus_req", 32'(bus_req_o), 32'h0);
    checkOutput("mis_ld_err", 32'(err_o), 32'h1);
    checkOutput("mis_ld_wb_valid", 32'(wb_valid_o), 32'h1);
    checkOutput("mis_ld_wb_rdata", wb_rdata_o, ERR_VAL);
    tick();
    checkOutput("mis_ld_err_pulse", 32'(err_o), 32'h0);

    // Misaligned store is suppressed
    applyStimulus(1'b1, 32'h201, 32'h1111_2222, WSEL_ALU, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, WSEL_ALU, 1'b0);
    checkOutput("mis_st_bus_req", 32'(bus_req_o), 32'h0);
    checkOutput("mis_st_err", 32'(err_o), 32'h1);
    checkOutput("mis_st_wb_aluc", wb_aluc_o, 32'h201);
    tick();

    // Timeout: no ack for 16 REQ cycles
    applyStimulus(1'b1, 32'h300, 32'h0, WSEL_DRAM, 1'b0);
    tick();
    n = 0;
    while (bus_req_o === 1'b1 && n < 40) begin
      n++;
      checkOutput("to_stall", 32'(stall_o), 32'(n < 16));
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, WSEL_ALU, 1'b0);
    checkOutput("to_req_cycles", 32'(n), 32'd16);
    checkOutput("to_err", 32'(err_o), 32'h1);
    checkOutput("to_wb_valid", 32'(wb_valid_o), 32'h1);
    checkOutput("to_wb_rdata", wb_rdata_o, ERR_VAL);
    tick();
    checkOutput("to_err_pulse", 32'(err_o), 32'h0);
    checkOutput("to_idle_req", 32'(bus_req_o), 32'h0);

    // Reset during the second REQ cycle drops everything at once
    applyStimulus(1'b1, 32'h400, 32'h0, WSEL_DRAM, 1'b0);
    tick();
    tick();
    checkOutput("rr_req_before", 32'(bus_req_o), 32'h1);
    rst_i = 1'b1;
    #1;
    checkOutput("rr_bus_req", 32'(bus_req_o), 32'h0);
    checkOutput("rr_stall", 32'(stall_o), 32'h0);
    checkOutput("rr_wb_valid", 32'(wb_valid_o), 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, WSEL_ALU, 1'b0);
    tick();
    rst_i = 1'b0;
    tick();

    applyStimulus(1'b1, 32'h500, 32'h0, WSEL_DRAM, 1'b0);
    bus_rdata_i = 32'h1234_5678;
    tick();
    checkOutput("rr_ld_addr", bus_addr_o, 32'h500);
    bus_ack_i = 1'b1;
    tick();
    bus_ack_i = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, WSEL_ALU, 1'b0);
    checkOutput("rr_ld_wb_valid", 32'(wb_valid_o), 32'h1);
    checkOutput("rr_ld_wb_rdata", wb_rdata_o, 32'h1234_5678);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
